// File: rtl/gpr_wr_arb.sv
// gpr_wr_arb: single GPR write-port arbiter (mem > ex > dbg, dbg anti-starvation) with sequenced clear
//   clk, reset (sync, active-low)
//   {mem,ex,dbg}_req/addr/data in, {mem,ex,dbg}_ack out (combinational grant)
//   clr_start in; busy, clr_done out (registered)
//   gpr_we_ (active-low), gpr_wr_addr, gpr_wr_data out (registered, drive the register file)
module gpr_wr_arb #(
  parameter int REG_NUM      = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_MAX   = 8,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ack,
  input  logic              ex_req,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  output logic              ex_ack,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ack,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic              gpr_we_,
  output logic [ADDR_W-1:0] gpr_wr_addr,
  output logic [DATA_W-1:0] gpr_wr_data
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t r_state, w_state_nx;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [SW-1:0] r_starve;
  logic r_pend;
  logic w_en, w_ovr, w_last, w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  // busy lags the state by one cycle, so both gate the acks: the cycle entering CLEAR
  // and the cycle presenting the last clear write grant nothing.
  // r_pend marks the first cycle out of reset when an automatic clear is about to start.
  always_comb begin
    w_last     = r_clr_idx == ADDR_W'(REG_NUM - 1);
    w_en       = reset && r_state == IDLE && !busy && !clr_start && !r_pend;
    w_ovr      = dbg_req && r_starve == SW'(STARVE_MAX);
    mem_ack    = w_en && mem_req && !w_ovr;
    ex_ack     = w_en && ex_req && !mem_req && !w_ovr;
    dbg_ack    = w_en && dbg_req && (w_ovr || (!mem_req && !ex_req));
    w_grant    = mem_ack || ex_ack || dbg_ack;
    w_addr     = mem_ack ? mem_addr : ex_ack ? ex_addr : dbg_addr;
    w_data     = mem_ack ? mem_data : ex_ack ? ex_data : dbg_data;
    w_state_nx = r_state == CLEAR ? (w_last ? IDLE : CLEAR)
               : ((clr_start && !busy) || r_pend) ? CLEAR : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_clr_idx   <= '0;
      r_starve    <= '0;
      r_pend      <= CLR_ON_RESET;
      busy        <= 1'b0;
      clr_done    <= 1'b0;
      gpr_we_     <= 1'b1;
      gpr_wr_addr <= '0;
      gpr_wr_data <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pend  <= 1'b0;
      if (r_state == CLEAR) begin
        gpr_we_     <= 1'b0;
        gpr_wr_addr <= r_clr_idx;
        gpr_wr_data <= '0;
        busy        <= 1'b1;
        clr_done    <= w_last;
        r_clr_idx   <= w_last ? '0 : r_clr_idx + 1'b1;
      end else begin
        gpr_we_  <= !w_grant;
        busy     <= 1'b0;
        clr_done <= 1'b0;
        if (w_grant) begin
          gpr_wr_addr <= w_addr;
          gpr_wr_data <= w_data;
        end
        if (!busy)
          r_starve <= (!dbg_req || dbg_ack) ? '0
                    : (r_starve == SW'(STARVE_MAX)) ? r_starve : r_starve + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gpr_wr_arb.sv
// tb_gpr_wr_arb: directed table-driven bench for gpr_wr_arb
module tb_gpr_wr_arb;
  logic clk = 1'b0, reset = 1'b0;
  logic mem_req = 1'b0, ex_req = 1'b0, dbg_req = 1'b0, clr_start = 1'b0;
  logic [4:0] mem_addr = '0, ex_addr = '0, dbg_addr = '0;
  logic [31:0] mem_data = '0, ex_data = '0, dbg_data = '0;
  logic mem_ack, ex_ack, dbg_ack, busy, clr_done, gpr_we_;
  logic [4:0] gpr_wr_addr;
  logic [31:0] gpr_wr_data;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  gpr_wr_arb dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .ex_req(ex_req), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ack(ex_ack),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ack(dbg_ack),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data)
  );
  typedef struct {
    logic m, e, d;
    logic [4:0] ma, ea, da;
    logic [31:0] md, ed, dd;
    logic [2:0] ack;
    logic we_n;
    logic [4:0] wa;
    logic [31:0] wd;
  } vec_t;
  vec_t tv[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_wr(input string nm, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({nm, ".we_"}, 32'(gpr_we_), 32'(we));
    chk({nm, ".addr"}, 32'(gpr_wr_addr), 32'(a));
    chk({nm, ".data"}, gpr_wr_data, d);
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, ".we_"}, 32'(gpr_we_), 32'd1);
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".clr_done"}, 32'(clr_done), 32'd0);
  endtask
  task automatic clear_run(input string nm, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      tick();
      chk_wr(nm, 1'b0, 5'(i), 32'd0);
      chk({nm, ".busy"}, 32'(busy), 32'd1);
      chk({nm, ".clr_done"}, 32'(clr_done), 32'(i == 31));
    end
  endtask
  initial begin
    tv[0]  = '{1, 1, 1, 5'd3, 5'd4, 5'd5, 32'hAAAA5555, 32'h1234, 32'hFFFF, 3'b100, 0, 5'd3, 32'hAAAA5555};
    tv[1]  = '{0, 1, 1, 5'd0, 5'd4, 5'd5, 32'h0, 32'h1234, 32'hFFFF, 3'b010, 0, 5'd4, 32'h1234};
    tv[2]  = '{0, 0, 1, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'hFFFF, 3'b001, 0, 5'd5, 32'hFFFF};
    tv[3]  = '{0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1, 5'd5, 32'hFFFF};
    tv[4]  = '{0, 1, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEAD, 32'h0, 3'b010, 0, 5'd0, 32'hDEAD};
    tv[5]  = '{1, 0, 1, 5'd9, 5'd0, 5'd10, 32'h99, 32'h0, 32'h10, 3'b100, 0, 5'd9, 32'h99};
    tv[6]  = '{0, 0, 1, 5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h10, 3'b001, 0, 5'd10, 32'h10};
    tv[7]  = '{0, 1, 1, 5'd0, 5'd12, 5'd12, 32'h0, 32'h1, 32'h2, 3'b010, 0, 5'd12, 32'h1};
    tv[8]  = '{0, 0, 1, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h2, 3'b001, 0, 5'd12, 32'h2};
    tv[9]  = '{1, 1, 0, 5'd31, 5'd30, 5'd0, 32'hCAFEF00D, 32'h5, 32'h0, 3'b100, 0, 5'd31, 32'hCAFEF00D};
    tv[10] = '{0, 0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1, 5'd31, 32'hCAFEF00D};
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("rst");
      chk("rst.mem_ack", 32'(mem_ack), 32'd0);
    end
    reset = 1'b1;
    mem_req = 1'b0;
    tick();
    chk_idle("rst_exit");
    clear_run("clr0", 0, 31);
    tick();
    chk_idle("clr0_end");
    foreach (tv[i]) begin
      {mem_req, ex_req, dbg_req} = {tv[i].m, tv[i].e, tv[i].d};
      {mem_addr, ex_addr, dbg_addr} = {tv[i].ma, tv[i].ea, tv[i].da};
      {mem_data, ex_data, dbg_data} = {tv[i].md, tv[i].ed, tv[i].dd};
      #1;
      chk($sformatf("vec%0d.acks", i), 32'({mem_ack, ex_ack, dbg_ack}), 32'(tv[i].ack));
      tick();
      chk_wr($sformatf("vec%0d", i), tv[i].we_n, tv[i].wa, tv[i].wd);
    end
    mem_req = 1'b1; mem_addr = 5'd1; mem_data = 32'h11;
    ex_req = 1'b1; ex_addr = 5'd2; ex_data = 32'h22;
    dbg_req = 1'b1; dbg_addr = 5'd6; dbg_data = 32'h66;
    #1;
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("starve%0d.mem_ack", k), 32'(mem_ack), 32'(k != 9));
      chk($sformatf("starve%0d.ex_ack", k), 32'(ex_ack), 32'd0);
      chk($sformatf("starve%0d.dbg_ack", k), 32'(dbg_ack), 32'(k == 9));
      tick();
      chk_wr($sformatf("starve%0d", k), 1'b0, k == 9 ? 5'd6 : 5'd1, k == 9 ? 32'h66 : 32'h11);
    end
    chk("starve_clr.mem_ack", 32'(mem_ack), 32'd1);
    chk("starve_clr.dbg_ack", 32'(dbg_ack), 32'd0);
    mem_req = 1'b0; ex_req = 1'b0; dbg_req = 1'b0;
    tick();
    ex_req = 1'b1; ex_addr = 5'd7; ex_data = 32'h77; clr_start = 1'b1;
    #1;
    chk("clr_start.ex_ack", 32'(ex_ack), 32'd0);
    tick();
    clr_start = 1'b0;
    #1;
    chk("clr_enter.ex_ack", 32'(ex_ack), 32'd0);
    chk_idle("clr_enter");
    for (int i = 0; i < 32; i++) begin
      tick();
      chk_wr($sformatf("clr1_%0d", i), 1'b0, 5'(i), 32'd0);
      chk($sformatf("clr1_%0d.busy", i), 32'(busy), 32'd1);
      chk($sformatf("clr1_%0d.clr_done", i), 32'(clr_done), 32'(i == 31));
      clr_start = (i == 10);
      #1;
      chk($sformatf("clr1_%0d.ex_ack", i), 32'(ex_ack), 32'd0);
    end
    tick();
    clr_start = 1'b0;
    #1;
    chk_idle("clr1_end");
    chk("clr1_end.ex_ack", 32'(ex_ack), 32'd1);
    tick();
    ex_req = 1'b0;
    chk_wr("ex_after_clr", 1'b0, 5'd7, 32'h77);
    mem_req = 1'b1; mem_addr = 5'd3; mem_data = 32'h3; reset = 1'b0;
    #1;
    chk("rst_idle.mem_ack", 32'(mem_ack), 32'd0);
    tick();
    mem_req = 1'b0;
    chk_idle("rst_idle");
    reset = 1'b1;
    tick();
    chk_idle("rst2_exit");
    clear_run("clr2", 0, 15);
    reset = 1'b0;
    tick();
    chk_idle("rst_in_clr");
    reset = 1'b1;
    tick();
    chk_idle("rst3_exit");
    clear_run("clr3", 0, 31);
    tick();
    chk_idle("clr3_end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
